sll_iterative: RTL
==================

# sll_iterative

Multicycle 32-bit logical left shifter for the ALU shift path. It is the left-direction counterpart of the combinational arithmetic-right-shift stages. One operand and a 5-bit shift amount are accepted through a valid/ready handshake. The shift is applied one power-of-two stage per cycle (16, 8, 4, 2, 1), and the result is held under a valid/ready output handshake. A sticky flag reports whether any set bit was shifted out.

## Interface
- WIDTH, 32, operand/result width (must be 32; stage sequence fixed to 16/8/4/2/1)
- SHW, 5, shift-amount width

- clock  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request (high only in IDLE)
- data_operandA  input  32  value to shift
- shamt  input  5  shift amount, 0..31, unsigned
- out_valid  output  1  result and lost_bits valid (high only in DONE)
- out_ready  input  1  consumer takes result
- result  output  32  data_operandA << shamt, zero-filled from bit 0
- lost_bits  output  1  1 if any 1-bit was shifted past bit 31

## Operation
- States: IDLE, SHIFT, DONE. There are no other states; any unreachable encoding returns to IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, on the next edge: capture data_operandA into the working register, capture shamt, set stage counter=0, clear lost_bits, go to SHIFT.
- SHIFT:
  - Each edge applies stage k (k=0..4, amount 16>>k) to the working register.
  - The stage shifts by that amount if shamt[4-k]=1, otherwise the register holds.
  - When a stage shifts, the bits leaving the top are the top (16>>k) bits of the working register. lost_bits |= OR of those bits.
  - After the stage-4 edge, go to DONE.
  - Every request takes all 5 stages, including shamt=0.
- DONE:
  - out_valid=1. result and lost_bits are stable.
  - On an edge with out_ready=1, go to IDLE. result keeps its last value and is not cleared.
- in_valid while not in IDLE is ignored. Requests are not queued, and captured inputs never change mid-operation.
- Input changes on data_operandA or shamt after capture have no effect.
- Arithmetic:
  - Zero fill only; no sign handling.
  - lost_bits is exactly (data_operandA >> (32-shamt)) != 0 for shamt>0, and 0 for shamt=0.

## Timing
- Reset values (asserted asynchronously, immediately): state=IDLE, in_ready=1, out_valid=0, result=0, lost_bits=0, stage counter=0.
- Reset deassertion is synchronized externally. The first accept can happen on the first edge with reset_n=1.
- Reset mid-SHIFT or mid-DONE aborts the operation with no output pulse. All outputs take their reset values.
- Latency:
  - Accept on edge E0.
  - Stages are applied on edges E1..E5.
  - out_valid rises after E5, i.e. 5 cycles after the accept edge.
- The result is presented in DONE and held for as long as out_ready=0.
- out_ready=1 in the first DONE cycle: the drain occurs on the next edge. in_ready rises in the following cycle.
- There is no same-cycle accept-and-drain. Minimum request-to-request spacing is 7 cycles: accept edge, 5 stage edges, drain edge.
- Combinational paths: in_ready and out_valid are decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Basic shift: data_operandA=0x00000001, shamt=31 -> result=0x80000000, lost_bits=0. out_valid rises exactly 5 cycles after accept.
- Lost bits: 0xFFFFFFFF, shamt=4 -> 0xFFFFFFF0, lost_bits=1. Also 0x0FFFFFFF, shamt=4 -> 0xFFFFFFF0, lost_bits=0.
- Zero shift: 0x12345678, shamt=0 -> 0x12345678, lost_bits=0, still 5-cycle latency. Sweep all 32 shamt values against the reference expression.
- Backpressure: hold out_ready=0 for 3 DONE cycles -> result, lost_bits and out_valid are stable. Then out_ready=1 -> IDLE on the next edge, in_ready=1 in the cycle after.
- Busy ignore: pulse in_valid with different operands during SHIFT and DONE -> no effect on result. The second request is only accepted once in_ready=1.
- Reset mid-operation: drop reset_n during the 3rd SHIFT cycle -> out_valid=0, result=0, in_ready=1 immediately. No stale result appears after release.

Source files
------------

// File: rtl/sll_iterative.sv
// sll_iterative: multicycle 32-bit logical left shifter.
// The shift amount is decomposed into power-of-two stages (16, 8, 4, 2, 1),
// one stage per clock. Every request walks all five stages, so latency is
// fixed regardless of shamt. A sticky flag records any 1-bit pushed past bit 31.
module sll_iterative #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             lost_bits
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [2:0] LAST_STAGE = 3'd4;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             lost_q, lost_d;

  // Per-stage candidate: shifted value, bits leaving the top, stage enable
  logic [WIDTH-1:0] stg_val;
  logic             stg_spill;
  logic             stg_en;

  // Select the current stage: amount 16>>cnt, gated by shamt bit (4-cnt)
  always_comb begin
    stg_val   = work_q;
    stg_spill = 1'b0;
    stg_en    = 1'b0;
    case (cnt_q)
      3'd0: begin
        stg_val   = {work_q[15:0], 16'b0};
        stg_spill = |work_q[31:16];
        stg_en    = shamt_q[4];
      end
      3'd1: begin
        stg_val   = {work_q[23:0], 8'b0};
        stg_spill = |work_q[31:24];
        stg_en    = shamt_q[3];
      end
      3'd2: begin
        stg_val   = {work_q[27:0], 4'b0};
        stg_spill = |work_q[31:28];
        stg_en    = shamt_q[2];
      end
      3'd3: begin
        stg_val   = {work_q[29:0], 2'b0};
        stg_spill = |work_q[31:30];
        stg_en    = shamt_q[1];
      end
      3'd4: begin
        stg_val   = {work_q[30:0], 1'b0};
        stg_spill = work_q[31];
        stg_en    = shamt_q[0];
      end
      default: begin
        stg_val   = work_q;
        stg_spill = 1'b0;
        stg_en    = 1'b0;
      end
    endcase
  end

  // Next-state and datapath updates; handshake outputs depend on state only
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    shamt_d   = shamt_q;
    cnt_d     = cnt_q;
    lost_d    = lost_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = data_operandA;
          shamt_d = shamt;
          cnt_d   = 3'd0;
          lost_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (stg_en) begin
          work_d = stg_val;
          lost_d = lost_q | stg_spill;
        end
        if (cnt_q == LAST_STAGE) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      shamt_q <= '0;
      cnt_q   <= 3'd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
    end
  end

  assign result    = work_q;
  assign lost_bits = lost_q;

endmodule
